sample_timer_ctrl: RTL
======================

// Module: sample_timer_ctrl
// PURPOSE
//  Programmable controller for the shared sample-tick counter used by the io_circuits
//  (debouncers, pollers). Replaces the hard-wired terminal count with a register-configured
//  period, run/stop control, periodic or one-shot mode and a sticky expiry flag with
//  interrupt. Sits behind the CPU MMIO decoder; drives sample_tick to downstream circuits.
// PARAMETERS
//  WIDTH           16          counter/period/data width
//  DEFAULT_PERIOD  16'd65000   PERIOD register reset value (terminal count)
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  cfg_we       in   1      register write strobe, one cycle per write
//  cfg_addr     in   3      register select
//  cfg_wdata    in   WIDTH  write data
//  cfg_rdata    out  WIDTH  read data, combinational from cfg_addr
//  sample_tick  out  1      registered one-cycle pulse per expiry
//  count        out  WIDTH  current counter value
//  irq          out  1      flag & irq_en, registered
// BEHAVIOUR
//  Registers: 0 CTRL {irq_en[2], oneshot[1], enable[0]}; 1 PERIOD; 2 STATUS {expired[0]}, W1C;
//   3 COUNT (read; any write clears count to 0); 4 PRESCALE (see CONFIGURATION); 5-7 read 0,
//   writes ignored.
//  Reset: CTRL=0, PERIOD=DEFAULT_PERIOD, count=0, expired=0, sample_tick=0, irq=0, state IDLE.
//  FSM: IDLE -> RUN when enable=1. RUN -> IDLE when enable cleared (count held, not cleared).
//   RUN -> DONE at expiry if oneshot=1. DONE -> RUN on any CTRL write with enable=1
//   (count restarts from 0); DONE -> IDLE on CTRL write with enable=0.
//  RUN: count increments by 1 per advance. Expiry = advance with count >= PERIOD: count -> 0,
//   sample_tick=1 the following cycle (1-cycle latency), expired set. Sequence 0..PERIOD gives
//   one tick every PERIOD+1 advances; PERIOD=0 gives a tick every advance.
//  Comparison is >=: PERIOD lowered below current count expires on the next advance; count
//   never wraps through 2^WIDTH.
//  DONE: count held at 0, no ticks. IDLE: count held, no ticks.
//  Simultaneous events: expiry and STATUS W1C in same cycle -> expired stays 1 (set wins).
//   COUNT write and advance in same cycle -> count=0, no expiry that cycle. PERIOD write
//   takes effect on the next cycle's compare.
//  irq = expired & irq_en, registered (one-cycle lag from expired/irq_en).
//  rst mid-count returns every register and the FSM to reset values on that edge.
// CONFIGURATION
//  SAMPLE_TIMER_PRESCALE_EN defined: addr 4 is an 8-bit PRESCALE register (reset 0, upper
//   bits read 0). An internal 8-bit prescaler counts 0..PRESCALE while in RUN; one advance of
//   count per prescaler wrap (PRESCALE=0 -> every cycle). Prescaler clears on leaving RUN,
//   on COUNT write and on rst.
//  Not defined: addr 4 reads 0, writes ignored; count advances every RUN cycle.
// TESTING
//  1 rst, write PERIOD=3, CTRL=1 -> count 0,1,2,3,0..., sample_tick every 4 cycles, one cycle
//    after count==3; expired=1 after first tick.
//  2 PERIOD=2, CTRL=3 (oneshot) -> exactly one tick after 3 cycles, state DONE, count 0;
//    rewrite CTRL=3 -> another single tick.
//  3 PERIOD=100, run to count=50, write PERIOD=10 -> expiry on next advance, count -> 0.
//  4 CTRL=5, PERIOD=1: irq rises one cycle after expired; W1C STATUS on an expiry cycle ->
//    expired stays 1; W1C on a non-expiry cycle -> expired 0, irq 0 one cycle later.
//  5 assert rst with count=7, CTRL=1 -> next cycle count=0, CTRL=0, PERIOD=65000, no ticks.
//  6 (PRESCALE_EN) PRESCALE=3, PERIOD=1 -> count advances every 4 cycles, tick every 8.

Source files
------------

// File: rtl/sample_timer_ctrl.sv
// Purpose  : programmable sample-tick timer (period, run/stop, one-shot, sticky expiry + irq).
// Latency  : sample_tick and expired follow the expiring advance by one cycle; irq lags expired by one more.
// Backpress: none; MMIO writes are single-cycle strobes and always accepted.
//
// Ports:
//   clk, rst     - rising-edge clock, synchronous active-high reset
//   cfg_we       - register write strobe (one cycle per write)
//   cfg_addr     - register select: 0 CTRL {irq_en,oneshot,enable}, 1 PERIOD,
//                  2 STATUS {expired} (W1C), 3 COUNT (write clears), 4 PRESCALE, 5-7 reserved
//   cfg_wdata    - write data
//   cfg_rdata    - read data, combinational from cfg_addr
//   sample_tick  - one-cycle pulse per expiry
//   count        - current counter value
//   irq          - registered expired & irq_en
//
// Build option: define SAMPLE_TIMER_PRESCALE_EN to add the 8-bit PRESCALE register at
// address 4. Without it, address 4 reads 0 and the counter advances on every RUN cycle.

module sample_timer_ctrl #(
  parameter int               WIDTH          = 16,
  parameter logic [WIDTH-1:0] DEFAULT_PERIOD = 16'd65000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [2:0]       cfg_addr,
  input  logic [WIDTH-1:0] cfg_wdata,
  output logic [WIDTH-1:0] cfg_rdata,
  output logic             sample_tick,
  output logic [WIDTH-1:0] count,
  output logic             irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_nxt;

  logic             enable, oneshot, irq_en;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] count_q;
  logic             expired;
  logic             tick_q;
  logic             irq_q;

  logic             ctrl_wr, period_wr, status_wr, count_wr;
  logic             enable_nxt;
  logic             pre_wrap;
  logic             advance;
  logic             expire;

  assign ctrl_wr   = cfg_we && (cfg_addr == 3'd0);
  assign period_wr = cfg_we && (cfg_addr == 3'd1);
  assign status_wr = cfg_we && (cfg_addr == 3'd2);
  assign count_wr  = cfg_we && (cfg_addr == 3'd3);

  // Enable as it will be after this cycle, so a CTRL write steers the FSM on the same edge.
  assign enable_nxt = ctrl_wr ? cfg_wdata[0] : enable;

`ifdef SAMPLE_TIMER_PRESCALE_EN
  logic       prescale_wr;
  logic [7:0] prescale;
  logic [7:0] pre_cnt;

  assign prescale_wr = cfg_we && (cfg_addr == 3'd4);
  // >= so lowering PRESCALE below the running prescaler wraps at once instead of rolling over.
  assign pre_wrap    = (pre_cnt >= prescale);

  always_ff @(posedge clk) begin
    if (rst) begin
      prescale <= 8'd0;
      pre_cnt  <= 8'd0;
    end else begin
      if (prescale_wr) begin
        prescale <= cfg_wdata[7:0];
      end
      if ((state != RUN) || (state_nxt != RUN) || count_wr || pre_wrap) begin
        pre_cnt <= 8'd0;
      end else begin
        pre_cnt <= pre_cnt + 8'd1;
      end
    end
  end
`else
  assign pre_wrap = 1'b1;
`endif

  assign advance = (state == RUN) && pre_wrap;
  // A COUNT write wins over the advance: the counter is cleared and that cycle cannot expire.
  assign expire  = advance && !count_wr && (count_q >= period);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (enable_nxt) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (!enable_nxt) begin
          state_nxt = IDLE;
        end else if (expire && oneshot) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        // Only a fresh CTRL write leaves DONE; enable stays set from the original arm.
        if (ctrl_wr) begin
          state_nxt = cfg_wdata[0] ? RUN : IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Registers, counter, flags
  always_ff @(posedge clk) begin
    if (rst) begin
      enable  <= 1'b0;
      oneshot <= 1'b0;
      irq_en  <= 1'b0;
      period  <= DEFAULT_PERIOD;
      count_q <= '0;
      expired <= 1'b0;
      tick_q  <= 1'b0;
      irq_q   <= 1'b0;
    end else begin
      if (ctrl_wr) begin
        irq_en  <= cfg_wdata[2];
        oneshot <= cfg_wdata[1];
        enable  <= cfg_wdata[0];
      end
      if (period_wr) begin
        period <= cfg_wdata;
      end

      // DONE is only entered through an expiry, so the counter is already 0 there and a
      // re-arm naturally restarts from 0.
      if (count_wr || expire) begin
        count_q <= '0;
      end else if (advance) begin
        count_q <= count_q + 1'b1;
      end

      // Expiry set has priority over a simultaneous W1C.
      if (expire) begin
        expired <= 1'b1;
      end else if (status_wr && cfg_wdata[0]) begin
        expired <= 1'b0;
      end

      tick_q <= expire;
      irq_q  <= expired & irq_en;
    end
  end

  // Read mux
  always_comb begin
    cfg_rdata = '0;
    case (cfg_addr)
      3'd0: cfg_rdata[2:0] = {irq_en, oneshot, enable};
      3'd1: cfg_rdata      = period;
      3'd2: cfg_rdata[0]   = expired;
      3'd3: cfg_rdata      = count_q;
`ifdef SAMPLE_TIMER_PRESCALE_EN
      3'd4: cfg_rdata[7:0] = prescale;
`endif
      default: cfg_rdata = '0;
    endcase
  end

  assign sample_tick = tick_q;
  assign count       = count_q;
  assign irq         = irq_q;

endmodule
